// File: rtl/proc_pkg.sv
// Shared types and constants for the issue / register-file slice.
//   DATA_W, NREG, AW : operand width, register count, register address width
//   reg_addr_t, data_t, opnd_bundle_t : register index, operand word, bundle
//   onehot()         : decoded register mask, all-zero when not enabled
package proc_pkg;
   localparam int DATA_W = 8;
   localparam int NREG   = 8;
   localparam int AW     = $clog2(NREG);

   typedef logic [AW-1:0]     reg_addr_t;
   typedef logic [DATA_W-1:0] data_t;

   typedef struct packed {
      data_t     a;
      data_t     b;
      reg_addr_t dst;
      logic      wr;
   } opnd_bundle_t;

   function automatic logic [NREG-1:0] onehot(input reg_addr_t r, input logic en);
      return en ? (NREG'(1) << r) : '0;
   endfunction
endpackage

// File: rtl/reg_scoreboard.sv
// Busy-register scoreboard.
//   clk, rst            : clock, async active-high reset
//   set_en / set_idx    : mark a register as having a write in flight
//   clr_en / clr_idx    : writeback retires the register
//   busy                : bit r set = write to r outstanding
//   err_wb_idle         : sticky, a writeback hit a register that was not busy
// A set and clear on the same register in one cycle leaves it busy: the new
// writer is younger than the one retiring.
module reg_scoreboard
   import proc_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            set_en,
   input  reg_addr_t       set_idx,
   input  logic            clr_en,
   input  reg_addr_t       clr_idx,
   output logic [NREG-1:0] busy,
   output logic            err_wb_idle
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy        <= '0;
         err_wb_idle <= 1'b0;
      end else begin
         busy <= (busy & ~onehot(clr_idx, clr_en)) | onehot(set_idx, set_en);
         if (clr_en && !busy[clr_idx])
            err_wb_idle <= 1'b1;
      end
   end
endmodule

// File: rtl/regfile_access_ctrl.sv
// Issue-side controller in front of the register file.
//   iss_*     : decoded op in (valid/ready), src1/src2/dst/wr
//   op_*      : operand bundle out to execute (valid/ready), a/b/dst/wr
//   wb_*      : writeback from execute, passed straight to the write port
//   rf_*      : register file read ports (a1/rd1, a2/rd2) and write port (a3/wd3/we3)
//   busy_mask : scoreboard view; err_wb_idle : sticky stray writeback
//   stall_cnt : saturating count of hazard-stall cycles
// Parameters default to the package constants; the bundle struct is sized by
// the package, so overrides must match it.
module regfile_access_ctrl #(
   parameter int DATA_W = proc_pkg::DATA_W,
   parameter int NREG   = proc_pkg::NREG,
   parameter int AW     = proc_pkg::AW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              iss_valid,
   output logic              iss_ready,
   input  logic [AW-1:0]     iss_src1,
   input  logic [AW-1:0]     iss_src2,
   input  logic [AW-1:0]     iss_dst,
   input  logic              iss_wr,
   output logic              op_valid,
   input  logic              op_ready,
   output logic [DATA_W-1:0] op_a,
   output logic [DATA_W-1:0] op_b,
   output logic [AW-1:0]     op_dst,
   output logic              op_wr,
   input  logic              wb_valid,
   input  logic [AW-1:0]     wb_dst,
   input  logic [DATA_W-1:0] wb_data,
   output logic [AW-1:0]     rf_a1,
   output logic [AW-1:0]     rf_a2,
   input  logic [DATA_W-1:0] rf_rd1,
   input  logic [DATA_W-1:0] rf_rd2,
   output logic [AW-1:0]     rf_a3,
   output logic [DATA_W-1:0] rf_wd3,
   output logic              rf_we3,
   output logic [NREG-1:0]   busy_mask,
   output logic              err_wb_idle,
   output logic [15:0]       stall_cnt
);
   import proc_pkg::*;

   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_eff;
   logic            src_haz, waw_haz, hazard, accept;
   data_t           byp_a, byp_b;
   opnd_bundle_t    bndl_q;

   assign rf_a1  = iss_src1;
   assign rf_a2  = iss_src2;
   assign rf_a3  = wb_dst;
   assign rf_wd3 = wb_data;
   assign rf_we3 = wb_valid;

   // The register retiring this cycle no longer blocks: its value is bypassed.
   assign busy_eff = busy & ~onehot(wb_dst, wb_valid);
   assign src_haz  = busy_eff[iss_src1] | busy_eff[iss_src2];
   assign waw_haz  = iss_wr & busy_eff[iss_dst];
   assign hazard   = src_haz | waw_haz;

   assign iss_ready = (!op_valid || op_ready) && !hazard;
   assign accept    = iss_valid && iss_ready;

   assign byp_a = (wb_valid && wb_dst == iss_src1) ? wb_data : rf_rd1;
   assign byp_b = (wb_valid && wb_dst == iss_src2) ? wb_data : rf_rd2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_valid  <= 1'b0;
         bndl_q    <= '0;
         stall_cnt <= '0;
      end else begin
         if (accept) begin
            op_valid <= 1'b1;
            bndl_q   <= '{a: byp_a, b: byp_b, dst: iss_dst, wr: iss_wr};
         end else if (op_ready) begin
            op_valid <= 1'b0;
         end
         // Back-pressure alone is not a hazard stall.
         if (iss_valid && hazard && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
      end
   end

   assign op_a   = bndl_q.a;
   assign op_b   = bndl_q.b;
   assign op_dst = bndl_q.dst;
   assign op_wr  = bndl_q.wr;

   // Source read happens this cycle, the busy bit lands at the edge, so an op
   // reading its own destination sees the old value.
   reg_scoreboard u_sb (
      .clk        (clk),
      .rst        (rst),
      .set_en     (accept && iss_wr),
      .set_idx    (iss_dst),
      .clr_en     (wb_valid),
      .clr_idx    (wb_dst),
      .busy       (busy),
      .err_wb_idle(err_wb_idle)
   );

   assign busy_mask = busy;
endmodule

// File: doc/regfile_access_ctrl.md
Name: regfile_access_ctrl

Overview:
- Issue-side controller in front of the 8x8 register file: drives both read ports and the write port.
- Accepts one decoded operation per cycle (src1, src2, dst) and fetches operands, bypassing the same-cycle writeback.
- Tracks outstanding writes in a scoreboard so RAW/WAW hazards stall issue; delivers operands to the execute stage over a valid/ready handshake.
- Writeback from the execute/ALU side is forwarded straight to the register file write port.

Parameters:
- DATA_W, 8, register/operand width
- NREG, 8, number of architectural registers
- AW, 3, register address width ($clog2(NREG))

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous active-high reset
- iss_valid  in  1  decoded op present
- iss_ready  out  1  op accepted this cycle when iss_valid && iss_ready
- iss_src1  in  AW  first source register
- iss_src2  in  AW  second source register
- iss_dst  in  AW  destination register
- iss_wr  in  1  op will write iss_dst
- op_valid  out  1  operand bundle valid
- op_ready  in  1  execute stage consumes bundle
- op_a  out  DATA_W  operand 1
- op_b  out  DATA_W  operand 2
- op_dst  out  AW  registered iss_dst
- op_wr  out  1  registered iss_wr
- wb_valid  in  1  writeback request
- wb_dst  in  AW  writeback register
- wb_data  in  DATA_W  writeback value
- rf_a1  out  AW  register file read address 1
- rf_a2  out  AW  register file read address 2
- rf_rd1  in  DATA_W  register file read data 1 (combinational)
- rf_rd2  in  DATA_W  register file read data 2 (combinational)
- rf_a3  out  AW  register file write address
- rf_wd3  out  DATA_W  register file write data
- rf_we3  out  1  register file write enable
- busy_mask  out  NREG  scoreboard: bit r set = write to r outstanding
- err_wb_idle  out  1  sticky: writeback to a register that was not busy
- stall_cnt  out  16  hazard-stall cycles, saturating at 16'hFFFF

Behaviour:
- Reset (async, rst=1): op_valid=0, op_a=0, op_b=0, op_dst=0, op_wr=0, busy_mask=0, err_wb_idle=0, stall_cnt=0. Register file contents are not reset and are preserved.
- Reset mid-operation: the in-flight bundle is dropped and the scoreboard is cleared. A late wb_valid after reset still writes the register file and sets err_wb_idle.
- Read ports: rf_a1=iss_src1 and rf_a2=iss_src2, combinational.
- Write port: rf_a3=wb_dst, rf_wd3=wb_data, rf_we3=wb_valid, combinational pass-through; the register file commits on the same posedge.
- Bypass: if wb_valid && wb_dst==iss_src1, the captured op_a is wb_data, otherwise rf_rd1. Same rule for op_b with iss_src2.
- Hazard conditions:
  - src_haz = (busy[src1] || busy[src2]) after masking out the register being written back this cycle.
  - waw_haz = iss_wr && busy[dst] && !(wb_valid && wb_dst==dst).
- Handshake: iss_ready = (!op_valid || op_ready) && !src_haz && !waw_haz. iss_ready may depend on iss_* fields; iss_valid must not depend on iss_ready.
- Latency: op accepted at edge N; op_valid=1 with its bundle from cycle N+1. Full throughput at 1 op/cycle with no hazards and op_ready=1.
- op_valid holds and the bundle stays stable until op_ready. On op_ready without a new accept, op_valid drops.
- Scoreboard update per edge:
  - Clear busy[wb_dst] on wb_valid.
  - Set busy[iss_dst] on accept with iss_wr.
  - If set and clear hit the same register, set wins.
- err_wb_idle is set when wb_valid && !busy[wb_dst] (pre-update value). It clears only on reset.
- stall_cnt increments on each cycle with iss_valid && !iss_ready caused by a hazard (not by back-pressure), and saturates.
- An op whose src equals its own dst is legal; the register is read before the busy bit is set.

Decomposition:
- Shared package (proc_pkg): DATA_W, NREG, AW constants; typedef reg_addr_t (logic [AW-1:0]); typedef data_t; packed struct opnd_bundle_t {data_t a, b; reg_addr_t dst; logic wr}.
- One natural sub-module: reg_scoreboard. It holds the busy vector with set/clear ports and set-wins priority, and provides the err_wb_idle check.

Test Plan:
- Register file preloaded R1=12, R2=27. Issue src1=1, src2=2, dst=3, wr=1, op_ready=1 -> next cycle op_a=12, op_b=27, op_dst=3, busy_mask=8'h08.
- Follow-up issue src1=3 while busy[3] -> iss_ready=0, stall_cnt counts each cycle. wb_valid dst=3 data=8'h27 in the same cycle as the retry -> accepted, op_a=8'h27 via bypass, busy[3]=0.
- Hold op_ready=0 for 3 cycles with op_valid=1 -> op_a/op_b/op_dst stable, iss_ready=0. Release -> next queued op appears one cycle later.
- busy[5] set, then issue dst=5 wr=1 -> WAW stall until wb_dst=5 arrives. Same-cycle clear+set leaves busy_mask bit5=1.
- wb_valid dst=6 with busy_mask=0 -> rf_we3=1, rf_a3=6, err_wb_idle=1 and sticky.
- Assert rst mid-stall with busy_mask=8'h28, op_valid=1 -> all outputs zero immediately (asynchronous). After deassert, issue of src=5 proceeds without stall.
